fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer between the program counter and instruction memory.
//  Owns the fetch PC, issues one valid/ready read per instruction and waits for the response.
//  Hands the fetched word to decode over a valid/ready interface.
//  Applies jump/branch redirects (dropping stale responses) and supports halt/resume.
// PARAMETERS
//  XLEN          32     address/data width
//  RESET_VECTOR  32'h0  PC loaded on reset
// PORTS
//  clk             in   1     clock, all state updates on rising edge
//  reset           in   1     synchronous, active-high
//  redirect_valid  in   1     jump/branch taken this cycle
//  redirect_pc     in   XLEN  redirect target; bits[1:0] forced to 0
//  halt_req        in   1     level; stop fetching after current instruction is handed off
//  imem_req_valid  out  1     read request valid
//  imem_req_addr   out  XLEN  read address (= pc)
//  imem_req_ready  in   1     memory accepts request
//  imem_rsp_valid  in   1     read data valid (exactly one per accepted request)
//  imem_rsp_data   in   XLEN  instruction word
//  if_valid        out  1     instruction available to decode
//  if_pc           out  XLEN  PC of if_instr
//  if_instr        out  XLEN  instruction word
//  if_ready        in   1     decode consumes instruction
//  halted          out  1     FSM in HALT
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_VECTOR, drop=0, imem_req_valid=0, if_valid=0,
//   if_pc=0, if_instr=0, halted=0. Reset mid-transaction abandons it; a late rsp is ignored (IDLE).
//  States: IDLE, REQ, WAIT, HOLD, HALT.
//  IDLE: -> REQ next cycle unconditionally (rsp_valid ignored).
//  REQ: imem_req_valid=1, addr=pc. req_ready -> WAIT. With redirect_valid the same cycle:
//   pc<=redirect_pc; if req_ready also high -> WAIT with drop=1, else stay REQ.
//  WAIT: req_valid=0. On rsp_valid: if drop -> drop<=0, -> REQ (data discarded);
//   else if_instr<=data, if_pc<=pc, pc<=pc+4, -> HOLD. redirect_valid in WAIT:
//   pc<=redirect_pc, drop<=1 (if rsp_valid same cycle, that rsp is discarded, -> REQ).
//  HOLD: if_valid=1, if_pc/if_instr stable. if_ready -> HALT if halt_req else REQ.
//   redirect_valid -> pc<=redirect_pc, if_valid drops next cycle, -> REQ (HALT if halt_req);
//   redirect with if_ready same cycle: instruction counts as consumed, redirect sets pc.
//  HALT: halted=1, no requests. redirect_valid -> pc<=redirect_pc, -> REQ (halt_req ignored
//   that cycle). Otherwise stays until reset.
//  halt_req in REQ/WAIT has no effect until HOLD hand-off; outstanding request always completes.
//  Latency: rsp_valid at cycle N -> if_valid at N+1; consume at M -> req_valid at M+1.
//  Arithmetic: pc+4 modulo 2^XLEN (32'hFFFF_FFFC -> 0); no overflow flag.
//  Priority: reset > redirect > halt > sequential increment.
//  Only one request outstanding; rsp_valid outside WAIT is ignored.
// STRUCTURE
//  Package fetch_pkg: state enum (IDLE/REQ/WAIT/HOLD/HALT), INSTR_BYTES=4, RESET_VECTOR default.
//  Sub-module fetch_pc_reg: PC register with sync reset, load (redirect) and increment enables.
//  FSM, drop flag and output holding register live in fetch_ctrl.
// TESTING
//  1 Reset, req_ready=1, rsp 1 cycle later, if_ready=1 -> addrs 0,4,8 issued; if_pc 0,4,8 in order.
//  2 if_ready=0 for 5 cycles in HOLD -> if_valid/if_pc/if_instr stable; no new req issued.
//  3 Redirect to 0x100 in WAIT; rsp 0xDEAD arrives -> discarded, next req addr=0x100, if_pc=0x100.
//  4 Redirect to 0x203 with req_ready same cycle in REQ -> drop=1, next req addr=0x200.
//  5 pc=0xFFFF_FFFC consumed -> next req addr=0x0.
//  6 halt_req=1 in WAIT -> instr delivered, after if_ready halted=1, no req; redirect 0x40 -> req 0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Fetch PC register: synchronous reset, redirect load (word-aligned) and sequential increment.
module fetch_pc_reg import fetch_pkg::*; #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q, pc_d;

  // Load beats increment; the increment wraps modulo 2^XLEN.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {load_pc_i[XLEN-1:2], 2'b00};
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: issues one imem read at a time, holds the word for decode,
// applies redirects (discarding stale responses) and supports halt/resume.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  input  logic            if_ready,
  output logic            halted
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            pc_load, pc_inc;
  logic [XLEN-1:0] pc;

  fetch_pc_reg #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        pc_load = redirect_valid;
        if (imem_req_ready) begin
          state_d = StWait;
          // A request accepted alongside a redirect fetches the old PC; mark it stale.
          drop_d  = redirect_valid;
        end
      end
      StWait: begin
        pc_load = redirect_valid;
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = StReq;
          end else begin
            if_instr_d = imem_rsp_data;
            if_pc_d    = pc;
            pc_inc     = 1'b1;
            state_d    = StHold;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      StHold: begin
        pc_load = redirect_valid;
        if (redirect_valid || if_ready) begin
          state_d = halt_req ? StHalt : StReq;
        end
      end
      StHalt: begin
        pc_load = redirect_valid;
        if (redirect_valid) begin
          state_d = StReq;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      drop_q     <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc;
  assign if_valid       = (state_q == StHold);
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign halted         = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized bench for fetch_ctrl: the bench plays imem and decode, and a transaction-level
// model (next fetch PC, outstanding read, held instruction, halted) predicts every output.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready;
  logic        halted;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .XLEN         (32),
    .RESET_VECTOR (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .if_ready       (if_ready),
    .halted         (halted)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic        m_idle;       // first cycle after reset: nothing happens
  logic        m_halted;
  logic        m_out;        // one read outstanding
  logic        m_stale;      // outstanding read made obsolete by a redirect
  logic [31:0] m_out_addr;
  logic        m_item;       // instruction held for decode
  logic [31:0] m_item_pc;
  logic [31:0] m_item_instr;
  logic [31:0] m_pc;         // next address the fetcher should request
  logic        m_just_reset;
  int unsigned n_deliv = 0;

  logic [31:0] targets [6];

  task automatic model_reset();
    m_idle   = 1'b1;
    m_halted = 1'b0;
    m_out    = 1'b0;
    m_stale  = 1'b0;
    m_item   = 1'b0;
    m_pc     = 32'h0;
  endtask

  initial begin
    logic        exp_req;
    logic [31:0] tgt;

    targets[0] = 32'h0000_0100;
    targets[1] = 32'h0000_0203;
    targets[2] = 32'hFFFF_FFFC;
    targets[3] = 32'h0000_0040;
    targets[4] = 32'hFFFF_FFF8;
    targets[5] = 32'h0000_1000;

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt_req       = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if_ready       = 1'b0;
    model_reset();
    m_just_reset = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);

      // Compare outputs settled after the previous rising edge
      exp_req = !m_idle && !m_halted && !m_out && !m_item;
      check_eq("req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check_eq("req_addr", imem_req_addr, m_pc);
      check_eq("if_valid", 32'(if_valid), 32'(m_item));
      if (m_item) begin
        check_eq("if_pc", if_pc, m_item_pc);
        check_eq("if_instr", if_instr, m_item_instr);
      end
      check_eq("halted", 32'(halted), 32'(m_halted));
      if (m_just_reset) begin
        check_eq("reset_if_pc", if_pc, 32'h0);
        check_eq("reset_if_instr", if_instr, 32'h0);
      end

      // Drive this cycle's inputs
      reset          = (cyc < 2) || ($urandom_range(0, 299) == 0);
      redirect_valid = ($urandom_range(0, 99) < 8);
      tgt            = ($urandom_range(0, 3) == 0) ? $urandom() : targets[$urandom_range(0, 5)];
      redirect_pc    = tgt;
      halt_req       = ($urandom_range(0, 99) < 10);
      imem_req_ready = ($urandom_range(0, 99) < 60);
      imem_rsp_valid = m_out ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 10);
      imem_rsp_data  = $urandom();
      if_ready       = ($urandom_range(0, 99) < 50);

      // Advance the model across the coming rising edge
      m_just_reset = reset;
      if (reset) begin
        model_reset();
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else if (m_halted) begin
        if (redirect_valid) begin
          m_pc     = tgt & 32'hFFFF_FFFC;
          m_halted = 1'b0;
        end
      end else if (m_item) begin
        if (redirect_valid || if_ready) begin
          m_item   = 1'b0;
          m_halted = halt_req;
          if (redirect_valid) m_pc = tgt & 32'hFFFF_FFFC;
        end
      end else if (m_out) begin
        if (imem_rsp_valid) begin
          m_out = 1'b0;
          if (!m_stale && !redirect_valid) begin
            m_item       = 1'b1;
            m_item_pc    = m_out_addr;
            m_item_instr = imem_rsp_data;
            m_pc         = m_out_addr + 32'd4;
            n_deliv++;
          end
        end else if (redirect_valid) begin
          m_stale = 1'b1;
        end
        if (redirect_valid) m_pc = tgt & 32'hFFFF_FFFC;
      end else begin
        if (imem_req_ready) begin
          m_out      = 1'b1;
          m_out_addr = m_pc;
          m_stale    = redirect_valid;
        end
        if (redirect_valid) m_pc = tgt & 32'hFFFF_FFFC;
      end
    end

    check_eq("progress", 32'(n_deliv > 100), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
